dp_sequencer: RTL

- Time-multiplexed controller for one FixedPointMultiplier/FixedPointAdder pair, which it uses to compute a PIXEL_N-term dot product (sum of Pixels[i]*Weights[i]).
- On a start request it latches the operand vectors and issues one multiply per element, waiting FPM_DELAY cycles for the result.
- It then issues one accumulate add per element, waiting FPA_DELAY cycles.
- It returns the final sum with a one-cycle done pulse.
- It sits between the neuron-level control and the shared FPM/FPA instances, which are external to this block.

---
 rtl/dp_pkg.sv | 19 +
 rtl/dp_delay_timer.sv | 35 +++
 rtl/dp_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding and
// the per-element cycle count derived from the multiplier/adder latencies.
package dp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_MUL_W = 3'd2,
    ST_ADD   = 3'd3,
    ST_ADD_W = 3'd4,
    ST_DONE  = 3'd5
  } dp_state_e;

  // One element costs an issue cycle plus the wait for each unit.
  function automatic int elem_cyc(input int fpm_delay, input int fpa_delay);
    return fpm_delay + fpa_delay + 2;
  endfunction

endpackage

// File: rtl/dp_delay_timer.sv
// Loadable up-counter used for both the multiplier and the adder waits;
// tc_o flags the final wait cycle so the FSM can capture the unit output.
module dp_delay_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == last_i);

endmodule

// File: rtl/dp_sequencer.sv
// Time-multiplexes one external multiplier/adder pair to accumulate a
// PIXEL_N-term dot product, returning the sum with a one-cycle done pulse.
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int PIXEL_N     = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int PIXEL_SIZE  = 10,
  parameter int VAL_SIZE    = 26,
  parameter int FPM_DELAY   = 6,
  parameter int FPA_DELAY   = 2
) (
  input  logic                          clk,
  input  logic                          GlobalReset,
  input  logic                          start,
  input  logic [PIXEL_N*PIXEL_SIZE-1:0] Pixels,
  input  logic [PIXEL_N*WEIGHT_SIZE-1:0] Weights,
  output logic                          ready,
  output logic                          done,
  output logic [VAL_SIZE-1:0]           value,
  output logic [WEIGHT_SIZE-1:0]        mul_weight,
  output logic [PIXEL_SIZE-1:0]         mul_pixel,
  input  logic [VAL_SIZE-1:0]           mul_result,
  output logic [VAL_SIZE-1:0]           add_port1,
  output logic [VAL_SIZE-1:0]           add_port2,
  input  logic [VAL_SIZE-1:0]           add_result
);

  localparam int IDX_W     = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1;
  localparam int MAX_DELAY = (FPM_DELAY > FPA_DELAY) ? FPM_DELAY : FPA_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_N - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(FPM_DELAY - 1);
  localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(FPA_DELAY - 1);

  dp_state_e state_q, state_d;

  logic [IDX_W-1:0]               idx_q, idx_d, idx_nxt;
  logic [VAL_SIZE-1:0]            acc_q, acc_d;
  logic [VAL_SIZE-1:0]            value_q, value_d;
  logic [PIXEL_N*PIXEL_SIZE-1:0]  pix_q, pix_d;
  logic [PIXEL_N*WEIGHT_SIZE-1:0] wgt_q, wgt_d;
  logic [WEIGHT_SIZE-1:0]         mul_weight_q, mul_weight_d;
  logic [PIXEL_SIZE-1:0]          mul_pixel_q, mul_pixel_d;
  logic [VAL_SIZE-1:0]            add_port1_q, add_port1_d;
  logic [VAL_SIZE-1:0]            add_port2_q, add_port2_d;

  logic [PIXEL_SIZE-1:0]          nxt_pixel;
  logic [WEIGHT_SIZE-1:0]         nxt_weight;

  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_last;
  logic             tmr_tc;
  logic             last_elem;

  dp_delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_i  (GlobalReset),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .last_i (tmr_last),
    .tc_o   (tmr_tc)
  );

  assign idx_nxt   = idx_q + IDX_W'(1);
  assign last_elem = (idx_q == LAST_IDX);

  // Operand mux for the element issued after the current one.
  always_comb begin
    nxt_pixel  = '0;
    nxt_weight = '0;
    for (int i = 0; i < PIXEL_N; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        nxt_pixel  = pix_q[i*PIXEL_SIZE +: PIXEL_SIZE];
        nxt_weight = wgt_q[i*WEIGHT_SIZE +: WEIGHT_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_MUL;
      ST_MUL:   state_d = ST_MUL_W;
      ST_MUL_W: if (tmr_tc) state_d = ST_ADD;
      ST_ADD:   state_d = ST_ADD_W;
      ST_ADD_W: if (tmr_tc) state_d = last_elem ? ST_DONE : ST_MUL;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == ST_IDLE);
    done     = (state_q == ST_DONE);
    tmr_load = (state_q == ST_MUL) || (state_q == ST_ADD);
    tmr_en   = (state_q == ST_MUL_W) || (state_q == ST_ADD_W);
    tmr_last = (state_q == ST_MUL_W) ? MUL_LAST : ADD_LAST;
  end

  // Operands are registered on entry to MUL/ADD so the external units see
  // them for the whole issue cycle plus the following wait.
  always_comb begin
    idx_d        = idx_q;
    acc_d        = acc_q;
    value_d      = value_q;
    pix_d        = pix_q;
    wgt_d        = wgt_q;
    mul_weight_d = mul_weight_q;
    mul_pixel_d  = mul_pixel_q;
    add_port1_d  = add_port1_q;
    add_port2_d  = add_port2_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pix_d        = Pixels;
          wgt_d        = Weights;
          acc_d        = '0;
          idx_d        = '0;
          mul_pixel_d  = Pixels[PIXEL_SIZE-1:0];
          mul_weight_d = Weights[WEIGHT_SIZE-1:0];
        end
      end
      ST_MUL_W: begin
        if (tmr_tc) begin
          add_port1_d = acc_q;
          add_port2_d = mul_result;
        end
      end
      ST_ADD_W: begin
        if (tmr_tc) begin
          acc_d = add_result;
          if (last_elem) begin
            value_d = add_result;
          end else begin
            idx_d        = idx_nxt;
            mul_pixel_d  = nxt_pixel;
            mul_weight_d = nxt_weight;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      idx_q        <= '0;
      acc_q        <= '0;
      value_q      <= '0;
      pix_q        <= '0;
      wgt_q        <= '0;
      mul_weight_q <= '0;
      mul_pixel_q  <= '0;
      add_port1_q  <= '0;
      add_port2_q  <= '0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      value_q      <= value_d;
      pix_q        <= pix_d;
      wgt_q        <= wgt_d;
      mul_weight_q <= mul_weight_d;
      mul_pixel_q  <= mul_pixel_d;
      add_port1_q  <= add_port1_d;
      add_port2_q  <= add_port2_d;
    end
  end

  assign value      = value_q;
  assign mul_weight = mul_weight_q;
  assign mul_pixel  = mul_pixel_q;
  assign add_port1  = add_port1_q;
  assign add_port2  = add_port2_q;

endmodule
